// File: rtl/gantry_pkg.sv
// Shared types and defaults for the gantry move sequencer.
package gantry_pkg;

  localparam int unsigned CoordW          = 3;
  localparam int unsigned DefStepsPerCell = 400;

  typedef logic [CoordW-1:0] coord_t;

  typedef enum logic [2:0] {
    StIdle,
    StLegXIssue,
    StLegXWait,
    StLegYIssue,
    StLegYWait,
    StSettle,
    StDone
  } state_e;

endpackage

// File: rtl/axis_leg_calc.sv
// Combinational leg planner for one axis: signed cell delta to direction, step count and
// a zero-motion flag.
module axis_leg_calc #(
  parameter int unsigned COORD_W        = 3,
  parameter int unsigned STEPS_PER_CELL = 400,
  parameter int unsigned STEP_W         = 32
) (
  input  logic signed [COORD_W:0] delta_i,
  output logic                    dir_o,
  output logic [STEP_W-1:0]       steps_o,
  output logic                    zero_o
);

  logic [COORD_W:0] mag;

  assign mag     = delta_i[COORD_W] ? unsigned'(-delta_i) : unsigned'(delta_i);
  assign zero_o  = (delta_i == '0);
  assign dir_o   = !delta_i[COORD_W] && !zero_o;
  assign steps_o = STEP_W'(mag) * STEP_W'(STEPS_PER_CELL);

endmodule

// File: rtl/gantry_move_sequencer.sv
// Gantry move sequencer: travel leg to the source cell, magnet on, carry leg to the
// destination cell, magnet off. X always moves before Y; axes are never run together.
module gantry_move_sequencer
  import gantry_pkg::*;
#(
  parameter int unsigned GRID_X         = 4,
  parameter int unsigned GRID_Y         = 5,
  parameter int unsigned COORD_W        = CoordW,
  parameter int unsigned STEPS_PER_CELL = DefStepsPerCell,
  parameter int unsigned STEP_W         = 32,
  parameter int unsigned SETTLE_CYC     = 2500000
) (
  input  logic               i_Clk,
  input  logic               i_rst,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [COORD_W-1:0] i_src_x,
  input  logic [COORD_W-1:0] i_src_y,
  input  logic [COORD_W-1:0] i_dst_x,
  input  logic [COORD_W-1:0] i_dst_y,
  output logic               o_x_en,
  output logic               o_x_direction,
  output logic [STEP_W-1:0]  o_x_total_steps,
  input  logic               i_x_done,
  output logic               o_y_en,
  output logic               o_y_direction,
  output logic [STEP_W-1:0]  o_y_total_steps,
  input  logic               i_y_done,
  output logic               o_magnet,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [COORD_W-1:0] o_pos_x,
  output logic [COORD_W-1:0] o_pos_y
);

  localparam int unsigned CntW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_e              state_q, state_d;
  logic                leg_q, leg_d;
  logic                skip_q, skip_d;
  logic                magnet_q, magnet_d;
  logic                err_q, err_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [COORD_W-1:0]  tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  logic [COORD_W-1:0]  dst_x_q, dst_x_d, dst_y_q, dst_y_d;
  logic [COORD_W-1:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic                x_dir_q, x_dir_d, y_dir_q, y_dir_d;
  logic [STEP_W-1:0]   x_steps_q, x_steps_d, y_steps_q, y_steps_d;

  logic signed [COORD_W:0] dx, dy;
  logic                    x_dir_c, y_dir_c, x_zero, y_zero;
  logic [STEP_W-1:0]       x_steps_c, y_steps_c;
  logic                    cmd_bad;

  assign dx = $signed({1'b0, tgt_x_q}) - $signed({1'b0, pos_x_q});
  assign dy = $signed({1'b0, tgt_y_q}) - $signed({1'b0, pos_y_q});

  assign cmd_bad = (32'(i_src_x) >= GRID_X) || (32'(i_dst_x) >= GRID_X) ||
                   (32'(i_src_y) >= GRID_Y) || (32'(i_dst_y) >= GRID_Y);

  axis_leg_calc #(
    .COORD_W        (COORD_W),
    .STEPS_PER_CELL (STEPS_PER_CELL),
    .STEP_W         (STEP_W)
  ) u_x_calc (
    .delta_i (dx),
    .dir_o   (x_dir_c),
    .steps_o (x_steps_c),
    .zero_o  (x_zero)
  );

  axis_leg_calc #(
    .COORD_W        (COORD_W),
    .STEPS_PER_CELL (STEPS_PER_CELL),
    .STEP_W         (STEP_W)
  ) u_y_calc (
    .delta_i (dy),
    .dir_o   (y_dir_c),
    .steps_o (y_steps_c),
    .zero_o  (y_zero)
  );

  // The issue state lasts one cycle, so the start pulse is decoded from it; direction and
  // steps come straight from the planner during the pulse and from the holding regs after.
  assign o_x_en          = (state_q == StLegXIssue) && !x_zero;
  assign o_x_direction   = o_x_en ? x_dir_c : x_dir_q;
  assign o_x_total_steps = o_x_en ? x_steps_c : x_steps_q;
  assign o_y_en          = (state_q == StLegYIssue) && !y_zero;
  assign o_y_direction   = o_y_en ? y_dir_c : y_dir_q;
  assign o_y_total_steps = o_y_en ? y_steps_c : y_steps_q;
  assign o_cmd_ready     = (state_q == StIdle);
  assign o_busy          = (state_q != StIdle);
  assign o_done          = (state_q == StDone);
  assign o_err           = err_q;
  assign o_magnet        = magnet_q;
  assign o_pos_x         = pos_x_q;
  assign o_pos_y         = pos_y_q;

  // Next-state logic for the move sequence.
  always_comb begin
    state_d   = state_q;
    leg_d     = leg_q;
    skip_d    = skip_q;
    magnet_d  = magnet_q;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    tgt_x_d   = tgt_x_q;
    tgt_y_d   = tgt_y_q;
    dst_x_d   = dst_x_q;
    dst_y_d   = dst_y_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    x_dir_d   = x_dir_q;
    x_steps_d = x_steps_q;
    y_dir_d   = y_dir_q;
    y_steps_d = y_steps_q;
    unique case (state_q)
      StIdle: begin
        if (i_cmd_valid) begin
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            tgt_x_d = i_src_x;
            tgt_y_d = i_src_y;
            dst_x_d = i_dst_x;
            dst_y_d = i_dst_y;
            leg_d   = 1'b0;
            state_d = StLegXIssue;
          end
        end
      end
      StLegXIssue: begin
        if (x_zero) begin
          state_d = StLegYIssue;
        end else begin
          x_dir_d   = x_dir_c;
          x_steps_d = x_steps_c;
          skip_d    = 1'b1;
          state_d   = StLegXWait;
        end
      end
      StLegXWait: begin
        // A done still asserted from the previous leg must not end this one.
        if (skip_q) begin
          skip_d = 1'b0;
        end else if (i_x_done) begin
          pos_x_d = tgt_x_q;
          state_d = StLegYIssue;
        end
      end
      StLegYIssue: begin
        if (y_zero) begin
          cnt_d    = CntW'(SETTLE_CYC - 1);
          magnet_d = !leg_q;
          state_d  = StSettle;
        end else begin
          y_dir_d   = y_dir_c;
          y_steps_d = y_steps_c;
          skip_d    = 1'b1;
          state_d   = StLegYWait;
        end
      end
      StLegYWait: begin
        if (skip_q) begin
          skip_d = 1'b0;
        end else if (i_y_done) begin
          pos_y_d  = tgt_y_q;
          cnt_d    = CntW'(SETTLE_CYC - 1);
          magnet_d = !leg_q;
          state_d  = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == '0) begin
          if (!leg_q) begin
            leg_d   = 1'b1;
            tgt_x_d = dst_x_q;
            tgt_y_d = dst_y_q;
            state_d = StLegXIssue;
          end else begin
            state_d = StDone;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset aborts any move, drops the magnet and returns to home.
  always_ff @(posedge i_Clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StIdle;
      leg_q     <= 1'b0;
      skip_q    <= 1'b0;
      magnet_q  <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      tgt_x_q   <= '0;
      tgt_y_q   <= '0;
      dst_x_q   <= '0;
      dst_y_q   <= '0;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      x_dir_q   <= 1'b0;
      x_steps_q <= '0;
      y_dir_q   <= 1'b0;
      y_steps_q <= '0;
    end else begin
      state_q   <= state_d;
      leg_q     <= leg_d;
      skip_q    <= skip_d;
      magnet_q  <= magnet_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      tgt_x_q   <= tgt_x_d;
      tgt_y_q   <= tgt_y_d;
      dst_x_q   <= dst_x_d;
      dst_y_q   <= dst_y_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      x_dir_q   <= x_dir_d;
      x_steps_q <= x_steps_d;
      y_dir_q   <= y_dir_d;
      y_steps_q <= y_steps_d;
    end
  end

endmodule

// File: tb/tb_gantry_move_sequencer.sv
// Directed bench for gantry_move_sequencer with motor models and pulse/magnet scoreboards.
module tb_gantry_move_sequencer;

  typedef struct packed {
    logic        dir;
    logic [31:0] steps;
  } pulse_t;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  src_x, src_y, dst_x, dst_y;
  logic        x_en, x_dir, x_done;
  logic [31:0] x_steps;
  logic        y_en, y_dir, y_done;
  logic [31:0] y_steps;
  logic        magnet, busy, done, err;
  logic [2:0]  pos_x, pos_y;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int n;

  pulse_t x_q[$];
  pulse_t y_q[$];
  logic   mag_q[$];
  logic   mag_prev = 1'b0;

  // Motor models: done pulse 5 cycles after the start pulse; X done can be forced high.
  int   x_cnt, y_cnt;
  logic x_done_p, y_done_p;
  logic hold_x = 1'b0;
  assign x_done = hold_x | x_done_p;
  assign y_done = y_done_p;

  gantry_move_sequencer #(
    .GRID_X         (4),
    .GRID_Y         (5),
    .COORD_W        (3),
    .STEPS_PER_CELL (4),
    .STEP_W         (32),
    .SETTLE_CYC     (3)
  ) dut (
    .i_Clk           (clk),
    .i_rst           (rst),
    .i_cmd_valid     (cmd_valid),
    .o_cmd_ready     (cmd_ready),
    .i_src_x         (src_x),
    .i_src_y         (src_y),
    .i_dst_x         (dst_x),
    .i_dst_y         (dst_y),
    .o_x_en          (x_en),
    .o_x_direction   (x_dir),
    .o_x_total_steps (x_steps),
    .i_x_done        (x_done),
    .o_y_en          (y_en),
    .o_y_direction   (y_dir),
    .o_y_total_steps (y_steps),
    .i_y_done        (y_done),
    .o_magnet        (magnet),
    .o_busy          (busy),
    .o_done          (done),
    .o_err           (err),
    .o_pos_x         (pos_x),
    .o_pos_y         (pos_y)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt <= 0; x_done_p <= 1'b0;
      y_cnt <= 0; y_done_p <= 1'b0;
    end else begin
      x_done_p <= 1'b0;
      y_done_p <= 1'b0;
      if (x_en) x_cnt <= 5;
      else if (x_cnt != 0) begin
        x_cnt <= x_cnt - 1;
        if (x_cnt == 1) x_done_p <= 1'b1;
      end
      if (y_en) y_cnt <= 5;
      else if (y_cnt != 0) begin
        y_cnt <= y_cnt - 1;
        if (y_cnt == 1) y_done_p <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors: every start pulse and magnet edge must match the next expected one.
  always @(negedge clk) begin
    pulse_t e;
    if (done) done_cnt++;
    if (x_en) begin
      if (x_q.size() == 0) check("x_unexpected_pulse", 32'(x_en), 0);
      else begin
        e = x_q.pop_front();
        check("x_dir", 32'(x_dir), 32'(e.dir));
        check("x_steps", x_steps, e.steps);
      end
    end
    if (y_en) begin
      if (y_q.size() == 0) check("y_unexpected_pulse", 32'(y_en), 0);
      else begin
        e = y_q.pop_front();
        check("y_dir", 32'(y_dir), 32'(e.dir));
        check("y_steps", y_steps, e.steps);
      end
    end
    if (magnet !== mag_prev) begin
      if (mag_q.size() == 0) check("magnet_unexpected", 32'(magnet), 32'(mag_prev));
      else check("magnet_edge", 32'(magnet), 32'(mag_q.pop_front()));
      mag_prev = magnet;
    end
  end

  task automatic issue(input logic [2:0] sx, input logic [2:0] sy,
                       input logic [2:0] tx, input logic [2:0] ty);
    @(negedge clk);
    check("ready_before_cmd", 32'(cmd_ready), 1);
    src_x = sx; src_y = sy; dst_x = tx; dst_y = ty;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Counts negedges after the accepting edge until o_done; then checks ready/busy timing.
  task automatic wait_done(input string tag, output int cyc);
    bit seen = 0;
    cyc = 0;
    while (!seen && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1;
    end
    if (!seen) check({tag, "_timeout"}, 32'(done), 1);
    else begin
      check({tag, "_ready_during_done"}, 32'(cmd_ready), 0);
      @(negedge clk);
      check({tag, "_ready_after_done"}, 32'(cmd_ready), 1);
      check({tag, "_busy_after_done"}, 32'(busy), 0);
    end
  endtask

  task automatic end_of_move(input string tag, input logic [2:0] ex, input logic [2:0] ey,
                             input int exp_done);
    check({tag, "_pos_x"}, 32'(pos_x), 32'(ex));
    check({tag, "_pos_y"}, 32'(pos_y), 32'(ey));
    check({tag, "_done_count"}, done_cnt, exp_done);
    check({tag, "_x_pending"}, x_q.size(), 0);
    check({tag, "_y_pending"}, y_q.size(), 0);
    check({tag, "_mag_pending"}, mag_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x_en"}, 32'(x_en), 0);
    check({tag, "_y_en"}, 32'(y_en), 0);
    check({tag, "_x_dir"}, 32'(x_dir), 0);
    check({tag, "_y_dir"}, 32'(y_dir), 0);
    check({tag, "_x_steps"}, x_steps, 0);
    check({tag, "_y_steps"}, y_steps, 0);
    check({tag, "_magnet"}, 32'(magnet), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_pos_x"}, 32'(pos_x), 0);
    check({tag, "_pos_y"}, 32'(pos_y), 0);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; cmd_valid = 1'b0;
    src_x = '0; src_y = '0; dst_x = '0; dst_y = '0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Move 1: (0,0) -> src(1,2) -> dst(1,3)
    x_q.push_back('{1'b1, 32'd4});
    y_q.push_back('{1'b1, 32'd8});
    y_q.push_back('{1'b1, 32'd4});
    mag_q.push_back(1'b1); mag_q.push_back(1'b0);
    issue(3'd1, 3'd2, 3'd1, 3'd3);
    wait_done("move1", n);
    @(negedge clk);
    end_of_move("move1", 3'd1, 3'd3, 1);

    // Move 2: back to home, zero-length carry leg
    x_q.push_back('{1'b0, 32'd4});
    y_q.push_back('{1'b0, 32'd12});
    mag_q.push_back(1'b1); mag_q.push_back(1'b0);
    issue(3'd0, 3'd0, 3'd0, 3'd0);
    wait_done("move2", n);
    @(negedge clk);
    end_of_move("move2", 3'd0, 3'd0, 2);

    // Out-of-range destination row: single error pulse, nothing moves
    issue(3'd0, 3'd0, 3'd0, 3'd5);
    @(negedge clk);
    check("err_pulse", 32'(err), 1);
    check("err_busy", 32'(busy), 0);
    @(negedge clk);
    check("err_pulse_end", 32'(err), 0);
    check("err_busy_after", 32'(busy), 0);
    repeat (10) @(negedge clk);
    end_of_move("err", 3'd0, 3'd0, 2);

    // X done held high: each leg still waits one ignored cycle, then advances
    hold_x = 1'b1;
    x_q.push_back('{1'b1, 32'd8});
    x_q.push_back('{1'b1, 32'd4});
    mag_q.push_back(1'b1); mag_q.push_back(1'b0);
    issue(3'd2, 3'd0, 3'd3, 3'd0);
    wait_done("hold", n);
    check("hold_latency", n, 15);
    hold_x = 1'b0;
    @(negedge clk);
    end_of_move("hold", 3'd3, 3'd0, 3);

    // Zero-motion move: both legs only settle
    mag_q.push_back(1'b1); mag_q.push_back(1'b0);
    issue(3'd3, 3'd0, 3'd3, 3'd0);
    wait_done("zero", n);
    check("zero_latency_in_range", 32'(n >= 10 && n <= 14), 1);
    @(negedge clk);
    end_of_move("zero", 3'd3, 3'd0, 4);

    // Reset during the carry-leg Y wait
    y_q.push_back('{1'b1, 32'd8});
    mag_q.push_back(1'b1); mag_q.push_back(1'b0);
    issue(3'd3, 3'd0, 3'd3, 3'd2);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (y_en) seen = 1;
    end
    if (!seen) check("rst_mid_y_pulse_timeout", 32'(y_en), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", 32'(cmd_ready), 1);
    end_of_move("rst_mid", 3'd0, 3'd0, 4);

    // Command while busy is dropped; the next one after o_done is taken once
    x_q.push_back('{1'b1, 32'd4});
    y_q.push_back('{1'b1, 32'd4});
    mag_q.push_back(1'b1); mag_q.push_back(1'b0);
    issue(3'd1, 3'd0, 3'd1, 3'd1);
    @(negedge clk);
    check("busy_ready_low", 32'(cmd_ready), 0);
    src_x = 3'd2; src_y = 3'd2; dst_x = 3'd3; dst_y = 3'd3;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_done("busy1", n);
    check("busy1_latency_nonzero", 32'(n > 5), 1);
    x_q.push_back('{1'b0, 32'd4});
    mag_q.push_back(1'b1); mag_q.push_back(1'b0);
    issue(3'd1, 3'd1, 3'd0, 3'd1);
    wait_done("busy2", n);
    repeat (10) @(negedge clk);
    end_of_move("busy2", 3'd0, 3'd1, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gantry_move_sequencer.md
Name: gantry_move_sequencer

Overview:
- Upstream command stage for the Klotski gantry: turns one piece move (source cell → destination cell) into step commands for the X and Y `Motor_Control` instances and drives the electromagnet.
- Tracks the gantry head's current cell and issues the travel leg to the source, then the carry leg to the destination.
- Sits between the solver/move-queue logic and the two motor controllers.

Parameters:
- GRID_X, 4, number of columns (x in 0..GRID_X-1)
- GRID_Y, 5, number of rows (y in 0..GRID_Y-1)
- COORD_W, 3, width of cell coordinates
- STEPS_PER_CELL, 400, motor steps per one-cell displacement
- STEP_W, 32, width of step-count outputs
- SETTLE_CYC, 2500000, magnet settle time in clocks (50 ms at 50 MHz)

Ports:
- i_Clk  in  1  system clock, 50 MHz
- i_rst  in  1  reset, asynchronous, active-high
- i_cmd_valid  in  1  move command valid
- o_cmd_ready  out  1  high only in IDLE; command accepted when valid&ready
- i_src_x / i_src_y  in  COORD_W  source cell
- i_dst_x / i_dst_y  in  COORD_W  destination cell
- o_x_en  out  1  one-cycle start pulse to X motor controller
- o_x_direction  out  1  1 = +x, held with o_x_en
- o_x_total_steps  out  STEP_W  step count, held with o_x_en
- i_x_done  in  1  X controller completion
- o_y_en / o_y_direction / o_y_total_steps / i_y_done  same for Y
- o_magnet  out  1  electromagnet enable
- o_busy  out  1  high outside IDLE
- o_done  out  1  one-cycle pulse, move complete
- o_err  out  1  one-cycle pulse, command rejected
- o_pos_x / o_pos_y  out  COORD_W  current head cell

Behaviour:
- Reset (async, i_rst=1): state IDLE; o_x_en, o_y_en, directions, step counts, o_magnet, o_busy, o_done, o_err = 0; o_pos = (0,0), defined as home.
- Reset mid-move: immediately aborts, drops the magnet and forces home position. The motor controllers are reset by the same reset.
- Accept: on valid&ready, latch src/dst.
  - If any coordinate ≥ GRID_X/GRID_Y, pulse o_err the next cycle and stay IDLE; no motor activity.
  - Otherwise set leg=0 (target=src) and go to LEG_X_ISSUE.
- LEG_X_ISSUE: dx = target_x − pos_x (signed).
  - If dx = 0, go directly to LEG_Y_ISSUE with no pulse.
  - Otherwise assert o_x_en for exactly one cycle with o_x_direction = (dx>0) and o_x_total_steps = |dx|·STEPS_PER_CELL (zero-extended to STEP_W), then go to LEG_X_WAIT.
  - Direction and steps hold their values until the next issue.
- LEG_X_WAIT: i_x_done is ignored on the first cycle after the pulse. Once i_x_done=1 is sampled, set pos_x = target_x and go to LEG_Y_ISSUE.
  - No timeout. i_x_done may be a level or a pulse.
- LEG_Y_ISSUE / LEG_Y_WAIT: identical, using the Y ports. On done, set pos_y = target_y and go to SETTLE.
- X always moves before Y. The two axes are never commanded concurrently.
- SETTLE: load counter with SETTLE_CYC−1 on entry and count down to 0.
  - Toggle o_magnet at entry: leg 0 sets it to 1, leg 1 clears it to 0.
  - At 0: if leg=0, set leg=1, target=dst and go to LEG_X_ISSUE; if leg=1, go to DONE.
- DONE: o_done=1 for one cycle, then IDLE. o_cmd_ready rises the cycle after the o_done pulse.
- src = current position: leg 0 issues no pulses but still settles. src = dst: magnet on/off cycle with no carry motion; this is legal.
- Unexpected i_x_done / i_y_done in any non-WAIT state is ignored.
- i_cmd_valid while busy is ignored (not queued).
- Latency of the zero-motion move with src=dst=pos: 2·SETTLE_CYC + 6 cycles ±2 from acceptance to o_done. The verifier checks the range, not an exact value.

Decomposition:
- Package `gantry_pkg`:
  - state enum (IDLE, LEG_X_ISSUE, LEG_X_WAIT, LEG_Y_ISSUE, LEG_Y_WAIT, SETTLE, DONE)
  - coordinate typedef
  - default STEPS_PER_CELL
- One sub-module, `axis_leg_calc`, is natural: combinational signed delta → {direction, |delta|·STEPS_PER_CELL, zero flag}. Instantiate it once per axis.

Test Plan (STEPS_PER_CELL=4, SETTLE_CYC=3, motor model asserts done 5 cycles after en):
- Reset, then command src(1,2) dst(1,3): X pulse dir=1 steps=4; Y pulse dir=1 steps=8; magnet 1; no X pulse on leg 1; Y pulse dir=1 steps=4; magnet 0; o_done once; pos=(1,3).
- From (1,3), command src(0,0) dst(0,0): X dir=0 steps=4; Y dir=0 steps=12; magnet on→off with no carry pulses; o_done; pos=(0,0).
- Command dst_y=5 (out of range): o_err one pulse, no o_x_en/o_y_en, o_busy stays 0, pos unchanged.
- Hold i_x_done=1 constantly: each X pulse is still issued, the first post-pulse cycle is ignored, advance on the second; no double issue.
- Assert i_rst during carry-leg Y wait: o_magnet=0, all outputs 0, pos=(0,0), o_cmd_ready=1 after release.
- Pulse i_cmd_valid while busy, then after o_done: first command ignored, second accepted exactly once.
